// File: rtl/mult8x8_seq_sched.sv
// mult8x8_seq_sched: sequential 8x8 unsigned multiplier that reuses a single
// 4x4 multiplier core over four cycles (LL, HL, LH, HH nibble pairs) and
// shift-accumulates the partial products into a 16-bit result. Operands and
// results use valid/ready handshakes; a completed-handshake counter is exported.
module mult8x8_seq_sched #(
    parameter int CORE_SEL = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      p,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_step;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [15:0]      r_acc;
    logic [15:0]      r_p;
    logic             r_outValid;
    logic [CNT_W-1:0] r_opCount;

    logic [3:0]       w_coreA;
    logic [3:0]       w_coreB;
    logic [7:0]       w_coreOut;
    logic [3:0]       w_shift;
    logic [15:0]      w_shifted;
    logic [15:0]      w_accNext;

    // 2x2 unsigned multiply at gate level, building block of the recursive core
    function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] y);
        logic c;
        logic [3:0] r;
        c    = x[1] & y[0] & x[0] & y[1];
        r[0] = x[0] & y[0];
        r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        r[2] = (x[1] & y[1]) ^ c;
        r[3] = x[1] & y[1] & c;
        return r;
    endfunction

    // step bit 0 picks the A nibble, step bit 1 picks the B nibble, so the
    // visiting order is LL, HL, LH, HH with weights 0, 4, 4, 8
    assign w_coreA = r_step[0] ? r_a[7:4] : r_a[3:0];
    assign w_coreB = r_step[1] ? r_b[7:4] : r_b[3:0];
    assign w_shift = {1'b0, (r_step[0] & r_step[1]), (r_step[0] ^ r_step[1]), 1'b0} << 1;

    generate
        if (CORE_SEL == 0) begin : g_colCore
            // column array: four AND rows, each offset by its multiplier bit
            logic [7:0] w_pp [4];
            for (genvar i = 0; i < 4; i++) begin : g_row
                assign w_pp[i] = {4'b0000, (w_coreA & {4{w_coreB[i]}})} << i;
            end
            assign w_coreOut = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];
        end else if (CORE_SEL == 1) begin : g_recCore
            // recursive split of the 4x4 product into four 2x2 products
            logic [7:0] w_ll;
            logic [7:0] w_hl;
            logic [7:0] w_lh;
            logic [7:0] w_hh;
            assign w_ll = {4'b0000, mul2x2(w_coreA[1:0], w_coreB[1:0])};
            assign w_hl = {4'b0000, mul2x2(w_coreA[3:2], w_coreB[1:0])};
            assign w_lh = {4'b0000, mul2x2(w_coreA[1:0], w_coreB[3:2])};
            assign w_hh = {4'b0000, mul2x2(w_coreA[3:2], w_coreB[3:2])};
            assign w_coreOut = w_ll + (w_hl << 2) + (w_lh << 2) + (w_hh << 4);
        end else begin : g_badSel
            $error("mult8x8_seq_sched: CORE_SEL must be 0 or 1");
        end
    endgenerate

    // partial product aligned to its nibble weight; the running sum tops out
    // at 255*255, so 16 bits never overflow
    assign w_shifted = {8'b0, w_coreOut} << w_shift;
    assign w_accNext = r_acc + w_shifted;

    // handshake and status outputs; acceptance is blocked while reset is held
    assign in_ready  = (r_state == IDLE) && !rst;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_outValid;
    assign p         = r_p;
    assign op_count  = r_opCount;

    // scheduler FSM: accept operands, run four core steps, hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_step  <= 2'd0;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // operand capture and accumulation of the shifted partial products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= 8'd0;
            r_b   <= 8'd0;
            r_acc <= 16'd0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= 16'd0;
            end
        end else if (r_state == MUL) begin
            r_acc <= w_accNext;
        end
    end

    // result register, output valid flag and completed-handshake counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p        <= 16'd0;
            r_outValid <= 1'b0;
            r_opCount  <= '0;
        end else if ((r_state == MUL) && (r_step == 2'd3)) begin
            r_p        <= w_accNext;
            r_outValid <= 1'b1;
        end else if ((r_state == DONE) && out_ready) begin
            r_outValid <= 1'b0;
            r_opCount  <= r_opCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mult8x8_seq_sched.sv
// Testbench for mult8x8_seq_sched: two instances share one stimulus stream,
// one with the column-array core and a 16-bit counter, one with the recursive
// core and a 2-bit counter, so core equivalence and counter wrap are covered.
module tb_mult8x8_seq_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;

    logic        inReady0, outValid0, busy0;
    logic        inReady1, outValid1, busy1;
    logic [15:0] p0, p1;
    logic [15:0] opCount0;
    logic [1:0]  opCount1;

    int          checks = 0;
    int          errors = 0;
    int          modelCount = 0;
    logic [15:0] lastP = 16'd0;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] expP;
        int          holdLow;
        bit          noise;
    } vec_t;

    vec_t vecs [7];

    mult8x8_seq_sched #(.CORE_SEL(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady0),
        .a(a), .b(b), .out_valid(outValid0), .out_ready(out_ready),
        .p(p0), .busy(busy0), .op_count(opCount0)
    );

    mult8x8_seq_sched #(.CORE_SEL(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady1),
        .a(a), .b(b), .out_valid(outValid1), .out_ready(out_ready),
        .p(p1), .busy(busy1), .op_count(opCount1)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // everything that reset must clear, on both instances
    task automatic checkResetState(input string tag);
        checkOutput({tag, " out_valid0"}, 32'(outValid0), 0);
        checkOutput({tag, " p0"}, 32'(p0), 0);
        checkOutput({tag, " busy0"}, 32'(busy0), 0);
        checkOutput({tag, " op_count0"}, 32'(opCount0), 0);
        checkOutput({tag, " out_valid1"}, 32'(outValid1), 0);
        checkOutput({tag, " p1"}, 32'(p1), 0);
        checkOutput({tag, " busy1"}, 32'(busy1), 0);
        checkOutput({tag, " op_count1"}, 32'(opCount1), 0);
    endtask

    // counters follow the number of handshakes, modulo each counter width
    task automatic checkCounts(input string tag);
        checkOutput({tag, " op_count0"}, 32'(opCount0), 32'(modelCount % 65536));
        checkOutput({tag, " op_count1"}, 32'(opCount1), 32'(modelCount % 4));
    endtask

    // one full operation: accept, wait for completion, optional back-pressure
    // and noisy inputs during MUL, then the output handshake
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [15:0] expP,
                                 input int holdLow, input bit noise, input string tag);
        int k;
        bit seen;
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1; out_ready = (holdLow == 0);
        checkOutput({tag, " in_ready idle"}, 32'(inReady0 & inReady1), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, " busy after accept"}, 32'(busy0 & busy1), 1);
        checkOutput({tag, " in_ready in MUL"}, 32'(inReady0 | inReady1), 0);
        checkOutput({tag, " p held before completion"}, 32'(p0), 32'(lastP));
        seen = 1'b0;
        for (k = 1; k <= 10; k++) begin
            if (outValid0) begin
                seen = 1'b1;
                break;
            end
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!seen) begin
            checkOutput({tag, " out_valid timeout"}, 0, 1);
        end
        checkOutput({tag, " latency edges"}, 32'(k - 1), 4);
        checkOutput({tag, " p0"}, 32'(p0), 32'(expP));
        checkOutput({tag, " p1"}, 32'(p1), 32'(expP));
        checkOutput({tag, " out_valid1"}, 32'(outValid1), 1);
        for (int h = 0; h < holdLow; h++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " held out_valid"}, 32'(outValid0 & outValid1), 1);
            checkOutput({tag, " held p"}, 32'(p0), 32'(expP));
            checkOutput({tag, " held in_ready"}, 32'(inReady0 | inReady1), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        modelCount++;
        lastP = expP;
        checkOutput({tag, " out_valid pulse end"}, 32'(outValid0 | outValid1), 0);
        checkOutput({tag, " back to idle"}, 32'(inReady0 & inReady1), 1);
        checkOutput({tag, " p kept after handshake"}, 32'(p0), 32'(expP));
        checkCounts(tag);
    endtask

    // three back-to-back pairs with in_valid and out_ready held high
    task automatic streamTest();
        int accepted;
        int nres;
        int lastCyc;
        bit took;
        logic [7:0] sa, sb;
        logic [15:0] expQ [$];
        accepted = 0; nres = 0; lastCyc = -1;
        @(negedge clk);
        sa = 8'($urandom); sb = 8'($urandom);
        a = sa; b = sb; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
            took = 1'b0;
            if (outValid0) begin
                if (expQ.size() > 0) begin
                    lastP = expQ.pop_front();
                end
                checkOutput("stream p0", 32'(p0), 32'(lastP));
                checkOutput("stream p1", 32'(p1), 32'(lastP));
                nres++;
                modelCount++;
            end
            if (inReady0 && in_valid) begin
                if (lastCyc >= 0) begin
                    checkOutput("stream accept spacing", 32'(cyc - lastCyc), 6);
                end
                lastCyc = cyc;
                expQ.push_back(16'(sa) * 16'(sb));
                accepted++;
                took = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (took) begin
                if (accepted < 3) begin
                    sa = 8'($urandom); sb = 8'($urandom);
                    a = sa; b = sb;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checkOutput("stream results", 32'(nres), 3);
        checkOutput("stream idle after", 32'(outValid0 | busy0), 0);
        checkCounts("stream");
    endtask

    initial begin
        vecs[0] = '{x: 8'hFF, y: 8'hFF, expP: 16'hFE01, holdLow: 0,  noise: 1'b0};
        vecs[1] = '{x: 8'hA5, y: 8'h3C, expP: 16'h26AC, holdLow: 0,  noise: 1'b0};
        vecs[2] = '{x: 8'h00, y: 8'h7F, expP: 16'h0000, holdLow: 0,  noise: 1'b0};
        vecs[3] = '{x: 8'h01, y: 8'h80, expP: 16'h0080, holdLow: 0,  noise: 1'b0};
        vecs[4] = '{x: 8'hC7, y: 8'h9E, expP: 16'h7AD2, holdLow: 10, noise: 1'b0};
        vecs[5] = '{x: 8'h6B, y: 8'hD4, expP: 16'h589C, holdLow: 0,  noise: 1'b1};
        vecs[6] = '{x: 8'h0F, y: 8'hF0, expP: 16'h0E10, holdLow: 2,  noise: 1'b1};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        checkOutput("reset in_ready low in reset", 32'(inReady0), 0);
        rst = 1'b0;
        #1;
        checkOutput("reset in_ready after release", 32'(inReady0 & inReady1), 1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].expP, vecs[i].holdLow, vecs[i].noise,
                          $sformatf("vec%0d", i));
        end

        // reset asserted between edges while step 2 is in progress
        @(negedge clk);
        a = 8'h5A; b = 8'hC3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("abort busy before reset", 32'(busy0), 1);
        rst = 1'b1;
        #1;
        checkResetState("abort");
        @(negedge clk);
        rst = 1'b0;
        modelCount = 0;
        lastP = 16'd0;
        repeat (5) @(negedge clk);
        checkOutput("abort no output", 32'(outValid0 | outValid1), 0);
        applyStimulus(8'h12, 8'h34, 16'h03A8, 0, 1'b0, "after abort");

        streamTest();

        // randomized operands against a plain arithmetic product
        for (int i = 0; i < 12; i++) begin
            logic [7:0] rx, ry;
            rx = 8'($urandom);
            ry = 8'($urandom);
            applyStimulus(rx, ry, 16'(rx) * 16'(ry), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                          $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
